// File: rtl/vga_pkg.sv
// Shared widget/VGA constants and the motion FSM state type.
package vga_pkg;

  localparam int POS_W        = 11;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    UPDATE,
    HOLD
  } state_t;

endpackage

// File: rtl/axis_step.sv
// One-axis bounce step: next position, next direction and reflect flag.
module axis_step
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF
) (
  input  logic [POS_W-1:0] pos,
  input  logic [8:0]       size,
  input  logic [4:0]       del,
  input  logic             dir,
  output logic [POS_W-1:0] pos_next,
  output logic             dir_next,
  output logic             hit
);

  localparam logic [11:0] LIM = 12'(ACTIVE);

  logic [11:0] ps;
  logic [11:0] sz;
  logic [11:0] dl;
  logic [11:0] far;
  logic [11:0] edge_pos;

  assign ps       = {1'b0, pos};
  assign sz       = {3'b0, size};
  assign dl       = {7'b0, del};
  assign far      = ps + sz + dl;
  assign edge_pos = LIM - sz;

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    hit      = 1'b0;
    if (sz >= LIM) begin
      pos_next = '0;
    end else if (del != '0) begin
      if (dir) begin
        if (far > LIM) begin
          pos_next = edge_pos[POS_W-1:0];
          dir_next = 1'b0;
          hit      = 1'b1;
        end else begin
          pos_next = pos + {6'b0, del};
        end
      end else begin
        if (ps < dl) begin
          pos_next = '0;
          dir_next = 1'b1;
          hit      = 1'b1;
        end else begin
          pos_next = pos - {6'b0, del};
        end
      end
    end
  end

endmodule

// File: rtl/widget_motion.sv
// Per-frame bouncing widget position, stepped once per VBlank.
// Optional WIDGET_MOTION_BOUNCE_CNT_EN adds an 8-bit bounce counter.
module widget_motion
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic             CLK_100MHz,
  input  logic             Reset,
  input  logic             enable,
  input  logic             VBlank,
  input  logic             run,
  input  logic [8:0]       xSize,
  input  logic [8:0]       ySize,
  input  logic [4:0]       delX,
  input  logic [4:0]       delY,
  input  logic [POS_W-1:0] firstX,
  input  logic [POS_W-1:0] firstY,
  output logic [POS_W-1:0] posX,
  output logic [POS_W-1:0] posY,
  output logic             dirX,
  output logic             dirY,
  output logic             bounce
`ifdef WIDGET_MOTION_BOUNCE_CNT_EN
  ,
  output logic [7:0]       bounceCount
`endif
);

  state_t state;
  state_t state_nxt;
  logic   vblank_q;

  logic [POS_W-1:0] nx;
  logic [POS_W-1:0] ny;
  logic             ndx;
  logic             ndy;
  logic             hx;
  logic             hy;

  axis_step #(.ACTIVE(H_ACTIVE)) u_x (
    .pos     (posX),
    .size    (xSize),
    .del     (delX),
    .dir     (dirX),
    .pos_next(nx),
    .dir_next(ndx),
    .hit     (hx)
  );

  axis_step #(.ACTIVE(V_ACTIVE)) u_y (
    .pos     (posY),
    .size    (ySize),
    .del     (delY),
    .dir     (dirY),
    .pos_next(ny),
    .dir_next(ndy),
    .hit     (hy)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (VBlank && !vblank_q && run)
          state_nxt = ARMED;
      end
      ARMED: begin
        // VBlank falling or run dropping beats a same-cycle enable
        if (!VBlank || !run)
          state_nxt = IDLE;
        else if (enable)
          state_nxt = UPDATE;
      end
      UPDATE: state_nxt = HOLD;
      HOLD: begin
        if (!VBlank)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!Reset) begin
      state    <= IDLE;
      vblank_q <= 1'b0;
      posX     <= firstX;
      posY     <= firstY;
      dirX     <= 1'b1;
      dirY     <= 1'b1;
      bounce   <= 1'b0;
    end else begin
      state    <= state_nxt;
      vblank_q <= VBlank;
      bounce   <= 1'b0;
      if (state == UPDATE) begin
        posX   <= nx;
        posY   <= ny;
        dirX   <= ndx;
        dirY   <= ndy;
        bounce <= hx | hy;
      end
    end
  end

`ifdef WIDGET_MOTION_BOUNCE_CNT_EN
  always_ff @(posedge CLK_100MHz) begin
    if (!Reset)
      bounceCount <= '0;
    else if (state == UPDATE && (hx || hy))
      bounceCount <= bounceCount + 8'd1;
  end
`endif

endmodule

// File: tb/tb_widget_motion.sv
// Randomized scoreboard bench for widget_motion against an integer model.
module tb_widget_motion;

  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        enable = 1'b0;
  logic        VBlank = 1'b0;
  logic        run = 1'b1;
  logic [8:0]  xSize = '0;
  logic [8:0]  ySize = '0;
  logic [4:0]  delX = '0;
  logic [4:0]  delY = '0;
  logic [10:0] firstX = '0;
  logic [10:0] firstY = '0;
  logic [10:0] posX;
  logic [10:0] posY;
  logic        dirX;
  logic        dirY;
  logic        bounce;
`ifdef WIDGET_MOTION_BOUNCE_CNT_EN
  logic [7:0]  bounceCount;
`endif

  widget_motion #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .CLK_100MHz(clk),
    .Reset     (Reset),
    .enable    (enable),
    .VBlank    (VBlank),
    .run       (run),
    .xSize     (xSize),
    .ySize     (ySize),
    .delX      (delX),
    .delY      (delY),
    .firstX    (firstX),
    .firstY    (firstY),
    .posX      (posX),
    .posY      (posY),
    .dirX      (dirX),
    .dirY      (dirY),
    .bounce    (bounce)
`ifdef WIDGET_MOTION_BOUNCE_CNT_EN
    ,
    .bounceCount(bounceCount)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int stamp;
    int x;
    int y;
    bit dx;
    bit dy;
    bit b;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  int px, py, bcnt;
  bit mdx, mdy;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int st, input bit b);
    q.push_back('{st, px, py, mdx, mdy, b});
  endtask

  task automatic axis(inout int p, inout bit d, input int sz,
                      input int dl, input int act, output bit h);
    h = 1'b0;
    if (sz >= act) p = 0;
    else if (dl == 0) p = p;
    else if (d && p + sz + dl > act) begin
      p = act - sz; d = 1'b0; h = 1'b1;
    end else if (d) p = p + dl;
    else if (p < dl) begin
      p = 0; d = 1'b1; h = 1'b1;
    end else p = p - dl;
  endtask

  task automatic model_step(output bit b);
    bit hx, hy;
    axis(px, mdx, int'(xSize), int'(delX), H, hx);
    axis(py, mdy, int'(ySize), int'(delY), V, hy);
    b = hx | hy;
    if (b) bcnt = (bcnt + 1) % 256;
  endtask

  task automatic do_reset(input int fx, input int fy);
    VBlank = 1'b0;
    enable = 1'b0;
    firstX = 11'(fx);
    firstY = 11'(fy);
    Reset  = 1'b0;
    tick(2);
    px = fx; py = fy; mdx = 1'b1; mdy = 1'b1; bcnt = 0;
    expect_at(cyc, 1'b0);
    Reset = 1'b1;
    tick(1);
  endtask

  task automatic frame(input int nen, input bit skip);
    int e;
    bit b;
    VBlank = 1'b1;
    tick(2);
    if (skip) begin
      VBlank = 1'b0;
      enable = 1'b1;
      e = cyc;
      expect_at(e + 2, 1'b0);
      expect_at(e + 3, 1'b0);
      tick(1);
      enable = 1'b0;
      tick(3);
    end else begin
      e = cyc;
      b = 1'b0;
      if (run) model_step(b);
      expect_at(e + 2, b);
      expect_at(e + 3, 1'b0);
      for (int i = 0; i < nen; i++) begin
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(1);
      end
      VBlank = 1'b0;
      tick(3);
    end
  endtask

  task automatic mid_reset(input int fx, input int fy);
    firstX = 11'(fx);
    firstY = 11'(fy);
    VBlank = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    Reset  = 1'b0;
    tick(1);
    px = fx; py = fy; mdx = 1'b1; mdy = 1'b1; bcnt = 0;
    expect_at(cyc, 1'b0);
    Reset  = 1'b1;
    VBlank = 1'b0;
    tick(3);
  endtask

  always @(negedge clk) begin
    exp_t t;
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      t = q.pop_front();
      checks++;
      if (t.stamp == cyc && posX == 11'(t.x) && posY == 11'(t.y) &&
          dirX == t.dx && dirY == t.dy && bounce == t.b)
        passed++;
      else
        $display("FAIL state@%0d: got x=%0d y=%0d dx=%0b dy=%0b b=%0b want x=%0d y=%0d dx=%0b dy=%0b b=%0b",
                 t.stamp, posX, posY, dirX, dirY, bounce,
                 t.x, t.y, t.dx, t.dy, t.b);
    end
  end

  initial begin
    run = 1'b1;
    xSize = 9'd20; ySize = 9'd20; delX = 5'd6; delY = 5'd4;
    do_reset(100, 50);
    frame(1, 1'b0);

    xSize = 9'd14; delX = 5'd6; ySize = 9'd10; delY = 5'd1;
    do_reset(620, 10);
    repeat (3) frame(1, 1'b0);

    xSize = 9'd458; ySize = 9'd359; delX = 5'd6; delY = 5'd4;
    do_reset(182, 121);
    repeat (32) frame(1, 1'b0);

    xSize = 9'd30; ySize = 9'd30; delX = 5'd5; delY = 5'd3;
    do_reset(300, 200);
    frame(3, 1'b0);
    frame(1, 1'b1);
    frame(1, 1'b0);

    mid_reset(77, 33);
    run = 1'b0;
    repeat (3) frame(1, 1'b0);
    run = 1'b1;
    frame(1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      xSize = 9'($urandom_range(0, 511));
      ySize = 9'($urandom_range(0, 511));
      delX  = 5'($urandom_range(0, 31));
      delY  = 5'($urandom_range(0, 31));
      run   = ($urandom_range(0, 3) != 0);
      frame($urandom_range(1, 3), $urandom_range(0, 4) == 0);
    end
    run = 1'b1;

`ifdef WIDGET_MOTION_BOUNCE_CNT_EN
    xSize = 9'd10; delX = 5'd0; ySize = 9'd460; delY = 5'd31;
    do_reset(5, 0);
    repeat (257) frame(1, 1'b0);
    checks++;
    if (int'(bounceCount) == bcnt) passed++;
    else $display("FAIL bounce_count: got %0d want %0d", bounceCount, bcnt);
`endif

    tick(5);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/widget_motion.md
# widget_motion

Per-frame motion controller that drives a widget's top-left position (`posX`, `posY`) so the widget bounces around the visible area. It sits directly upstream of the widget renderer, replacing its fixed `firstX`/`firstY` constants. Position changes only during vertical blanking, on the first clock-divider pulse after VBlank rises, so a frame is never drawn with a mid-frame position change. It runs on the 100 MHz system clock alongside the VGA driver.

## Interface

Parameters:
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in lines.

Ports:
- `CLK_100MHz`  in  1  system clock.
- `Reset`  in  1  synchronous reset, active-low.
- `enable`  in  1  one-cycle pulse from the clock divider.
- `VBlank`  in  1  vertical blanking flag from the VGA driver.
- `run`  in  1  when low, no steps are taken and position holds.
- `xSize`, `ySize`  in  9 each  widget width/height in pixels.
- `delX`, `delY`  in  5 each  step magnitude per frame.
- `firstX`, `firstY`  in  11 each  start position, loaded while `Reset` is low.
- `posX`, `posY`  out  11 each  registered widget position.
- `dirX`, `dirY`  out  1 each  direction: 1 = increasing, 0 = decreasing.
- `bounce`  out  1  one-cycle pulse when either axis reflects.

## Operation

- **Reset (Reset=0 at a clock edge):** `posX=firstX`, `posY=firstY`, `dirX=1`, `dirY=1`, `bounce=0`, state IDLE. VBlank edge register is cleared. Reset takes effect from any state, including UPDATE; any pending step is discarded.
- **FSM states:**
  - IDLE: on a VBlank rising edge (VBlank=1 and registered copy=0) with `run=1`, go to ARMED.
  - ARMED: `enable=1` goes to UPDATE. VBlank=0 returns to IDLE and the step is skipped for that frame. If both occur in the same cycle, VBlank falling wins and no update happens.
  - UPDATE: exactly one cycle. Registers position, direction and `bounce`, then goes to HOLD.
  - HOLD: when VBlank=0, go to IDLE. Guarantees at most one step per frame.
- **Per-axis step** (X shown; Y is identical with `ySize`, `delY`, `V_ACTIVE`). All sums are 12-bit, so there is no wrap.
  - dir=1: if `posX+xSize+delX > H_ACTIVE`, then `posX=H_ACTIVE-xSize`, `dirX=0`, bounce. Otherwise `posX=posX+delX`.
  - dir=0: if `posX < delX`, then `posX=0`, `dirX=1`, bounce. Otherwise `posX=posX-delX`.
  - Degenerate size (`xSize >= H_ACTIVE`): `posX=0`, dir unchanged, no bounce.
  - `delX=0`: position held, no bounce.
- **Bounce output:** the OR of both axes. A corner hit flips both directions and produces a single one-cycle pulse.
- **run=0:** IDLE does not arm. If `run` drops while ARMED, the FSM returns to IDLE without updating.

## Timing

- VBlank rising edge at cycle t is detected at t; ARMED from t+1.
- Enable pulse in cycle e while ARMED gives UPDATE at e+1. New `posX`/`posY`/`dir` and `bounce=1` are visible at e+2.
- `bounce` stays high for exactly one cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration

- `WIDGET_MOTION_BOUNCE_CNT_EN`
  - Defined: adds output `bounceCount` (8-bit). It increments by 1 on every `bounce` pulse, wraps 255→0, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure

- Package `vga_pkg` holds:
  - `POS_W=11`;
  - the default `H_ACTIVE`/`V_ACTIVE`;
  - the FSM state typedef (IDLE, ARMED, UPDATE, HOLD).
- Sub-module `axis_step`: combinational next-position, next-dir and bounce for one axis. Instantiated twice, once for X with `H_ACTIVE` and once for Y with `V_ACTIVE`.

## Test plan

- **Reset load:** `firstX=100`, `firstY=50` with Reset low, then release → `posX=100`, `posY=50`, `dirX=dirY=1`. After one VBlank rise plus an enable pulse with `delX=6`, `delY=4` → `106`, `54`, both visible 2 cycles after the enable pulse.
- **Right edge:** `xSize=14`, `delX=6`, `posX=620`, dirX=1 → first frame `626`, no bounce. Next frame `posX=626`, `dirX=0`, bounce=1 for 1 cycle. Frame after → `620`.
- **Corner:** `posX=2`, `posY=1`, dirX=dirY=0, `delX=6`, `delY=4` → `posX=0`, `posY=0`, both dirs=1, single bounce pulse.
- **One step per frame / skipped frame:**
  - Three enable pulses within one VBlank → exactly one step.
  - VBlank falls before any enable pulse → position unchanged for that frame.
- **Mid-operation reset and run gating:**
  - Reset asserted in the UPDATE cycle → outputs equal `firstX`/`firstY`, dirs=1, no bounce.
  - `run=0` over 3 frames → position constant.
- **Bounce counter** (with `WIDGET_MOTION_BOUNCE_CNT_EN`): 257 forced bounces → `bounceCount=1`.
